// File: rtl/irq_pkg.sv
// Shared constants, types and helpers for the interrupt arbiter.
package irq_pkg;

  localparam int unsigned NUM_SRC       = 32;
  localparam int unsigned NUM_GROUPS    = 8;
  localparam int unsigned SRC_PER_GROUP = 4;

  localparam logic [23:0] IRQ_PRIO = 24'h2020;
  localparam logic [23:0] IRQ_ENA  = 24'h2022;
  localparam logic [23:0] IRQ_ACT  = 24'h2026;

  typedef enum logic [1:0] {IDLE, REQ, GAP} irq_state_t;
  typedef logic [1:0] irq_prio_t;

  function automatic irq_prio_t src_prio(input logic [2*NUM_GROUPS-1:0] prio,
                                         input int unsigned src);
    return prio[2*(src/SRC_PER_GROUP) +: 2];
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Picks the eligible source with the highest group priority; ties go to the lowest index.
module irq_priority_encoder
  import irq_pkg::*;
(
  input  logic [NUM_SRC-1:0]      eligible,
  input  logic [2*NUM_GROUPS-1:0] prio,
  output logic                    any,
  output logic [4:0]              index,
  output irq_prio_t               level
);

  // Ascending scan with strict '>' keeps the lowest index on equal priority.
  always_comb begin
    any   = 1'b0;
    index = '0;
    level = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (eligible[s] && (!any || (src_prio(prio, s) > level))) begin
        any   = 1'b1;
        index = 5'(s);
        level = src_prio(prio, s);
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt pending/enable/priority registers on the system bus plus a req/ack
// handshake that presents one winning source to the CPU.
module irq_arbiter
  import irq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_ce_cpu,
  input  logic               bus_write,
  input  logic               bus_read,
  input  logic [23:0]        bus_address_in,
  input  logic [7:0]         bus_data_in,
  output logic [7:0]         bus_data_out,
  input  logic [NUM_SRC-1:0] irq_sources,
  input  logic [1:0]         cpu_ilevel,
  output logic               irq_req,
  output logic [4:0]         irq_index,
  output irq_prio_t          irq_level,
  input  logic               irq_ack
);

  logic [2*NUM_GROUPS-1:0] prio_q;
  logic [NUM_SRC-1:0]      enable_q;
  logic [NUM_SRC-1:0]      active_q, active_d;
  logic [NUM_SRC-1:0]      clr_mask;
  logic [NUM_SRC-1:0]      eligible;
  irq_state_t              state_q;

  logic                    wr_en;
  logic [23:0]             prio_off, ena_off, act_off;
  logic                    prio_hit, ena_hit, act_hit;

  logic                    win_any;
  logic [4:0]              win_index;
  irq_prio_t               win_level;

  // Reads have no side effects, so the strobe is not needed for decode.
  logic                    unused_bus_read;
  assign unused_bus_read = bus_read;

  assign wr_en    = clk_ce_cpu & bus_write;
  assign prio_off = bus_address_in - IRQ_PRIO;
  assign ena_off  = bus_address_in - IRQ_ENA;
  assign act_off  = bus_address_in - IRQ_ACT;
  // Addresses below a base wrap to large offsets and fail the range test.
  assign prio_hit = prio_off < 24'd2;
  assign ena_hit  = ena_off < 24'd4;
  assign act_hit  = act_off < 24'd4;

  always_comb begin
    clr_mask = '0;
    if (wr_en && act_hit) begin
      clr_mask[{act_off[1:0], 3'b000} +: 8] = bus_data_in;
    end
    // Set wins over a same-cycle software clear.
    active_d = (active_q & ~clr_mask) | irq_sources;
  end

  always_comb begin
    bus_data_out = '0;
    if (prio_hit) begin
      bus_data_out = prio_q[{prio_off[0], 3'b000} +: 8];
    end else if (ena_hit) begin
      bus_data_out = enable_q[{ena_off[1:0], 3'b000} +: 8];
    end else if (act_hit) begin
      bus_data_out = active_q[{act_off[1:0], 3'b000} +: 8];
    end
  end

  always_comb begin
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      eligible[s] = active_q[s] & enable_q[s] & (src_prio(prio_q, s) != 2'd0) &
                    (src_prio(prio_q, s) > cpu_ilevel);
    end
  end

  irq_priority_encoder u_encoder (
    .eligible (eligible),
    .prio     (prio_q),
    .any      (win_any),
    .index    (win_index),
    .level    (win_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q   <= '0;
      enable_q <= '0;
      active_q <= '0;
    end else begin
      if (wr_en && prio_hit) begin
        prio_q[{prio_off[0], 3'b000} +: 8] <= bus_data_in;
      end
      if (wr_en && ena_hit) begin
        enable_q[{ena_off[1:0], 3'b000} +: 8] <= bus_data_in;
      end
      active_q <= active_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      irq_req   <= 1'b0;
      irq_index <= '0;
      irq_level <= '0;
    end else if (clk_ce_cpu) begin
      unique case (state_q)
        IDLE: begin
          if (win_any) begin
            irq_index <= win_index;
            irq_level <= win_level;
            irq_req   <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (irq_ack) begin
            irq_req <= 1'b0;
            state_q <= GAP;
          end else if (!eligible[irq_index]) begin
            // Withdraw rather than deliver a vector that is no longer valid.
            irq_req <= 1'b0;
            state_q <= IDLE;
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          irq_req <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
